// File: rtl/alu_sweep_driver.sv
// -----------------------------------------------------------------------------
// alu_sweep_driver
//   Command-side driver for a select-coded combinational ALU. It accepts one
//   operand pair over a valid/ready handshake, holds it on the ALU inputs and
//   steps alu_select from 0 to all-ones. For each code it waits SETTLE cycles,
//   samples alu_out and offers the sample as one beat on a valid/ready result
//   stream. A done pulse follows acceptance of the final beat.
//
// Parameters
//   WIDTH   operand / result width
//   SEL_W   select width; one sweep produces 2**SEL_W beats
//   SETTLE  cycles alu_select is held before alu_out is sampled (1..15)
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   in_valid/in_ready         operand handshake (ready only while idle)
//   in_a, in_b                operand pair
//   alu_a, alu_b, alu_select  registered drive into the ALU
//   alu_out                   combinational ALU result
//   res_valid/res_ready       result stream handshake
//   res_data, res_select      sampled result and the code it belongs to
//   res_last                  marks the beat for the all-ones code
//   busy                      sweep in progress
//   done                      one-cycle pulse after the last beat is accepted
// -----------------------------------------------------------------------------
module alu_sweep_driver #(
    parameter int WIDTH  = 8,
    parameter int SEL_W  = 3,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_select,
    input  logic [WIDTH-1:0] alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [SEL_W-1:0] res_select,
    output logic             res_last,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    // Settle counter is a fixed 4-bit field, so SETTLE must stay within 1..15.
    localparam logic [3:0]       SETTLE_CNT = 4'(SETTLE);
    localparam logic [SEL_W-1:0] SEL_LAST   = {SEL_W{1'b1}};
    localparam logic [SEL_W-1:0] SEL_ONE    = SEL_W'(1);

    state_t           state_q,      state_d;
    logic [3:0]       cnt_q,        cnt_d;
    logic [WIDTH-1:0] alu_a_q,      alu_a_d;
    logic [WIDTH-1:0] alu_b_q,      alu_b_d;
    logic [SEL_W-1:0] alu_sel_q,    alu_sel_d;
    logic             res_valid_q,  res_valid_d;
    logic [WIDTH-1:0] res_data_q,   res_data_d;
    logic [SEL_W-1:0] res_sel_q,    res_sel_d;
    logic             res_last_q,   res_last_d;
    logic             busy_q,       busy_d;
    logic             done_q,       done_d;

    // Next-state and next-output computation for the sweep FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_sel_d   = res_sel_q;
        res_last_d  = res_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Operands are only latched here, so the ALU inputs hold the
                // last pair for the whole sweep and while idle.
                if (in_valid) begin
                    alu_a_d   = in_a;
                    alu_b_d   = in_b;
                    alu_sel_d = {SEL_W{1'b0}};
                    cnt_d     = SETTLE_CNT;
                    busy_d    = 1'b1;
                    state_d   = S_WAIT;
                end else begin
                    busy_d    = 1'b0;
                end
            end
            S_WAIT: begin
                // cnt==1 marks the edge after SETTLE cycles of stable select.
                if (cnt_q == 4'd1) begin
                    res_data_d  = alu_out;
                    res_sel_d   = alu_sel_q;
                    res_last_d  = (alu_sel_q == SEL_LAST);
                    res_valid_d = 1'b1;
                    state_d     = S_OUT;
                end else begin
                    cnt_d       = cnt_q - 4'd1;
                end
            end
            S_OUT: begin
                // Beat is held untouched until the consumer takes it.
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    if (res_last_q) begin
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        state_d   = S_IDLE;
                    end else begin
                        alu_sel_d = alu_sel_q + SEL_ONE;
                        cnt_d     = SETTLE_CNT;
                        state_d   = S_WAIT;
                    end
                end else begin
                    res_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                busy_d      = 1'b0;
                res_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            alu_a_q     <= {WIDTH{1'b0}};
            alu_b_q     <= {WIDTH{1'b0}};
            alu_sel_q   <= {SEL_W{1'b0}};
            res_valid_q <= 1'b0;
            res_data_q  <= {WIDTH{1'b0}};
            res_sel_q   <= {SEL_W{1'b0}};
            res_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_sel_q   <= res_sel_d;
            res_last_q  <= res_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // in_ready must drop as soon as rst is raised, so it is gated by rst directly.
    assign in_ready   = (state_q == S_IDLE) && !rst;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_select = alu_sel_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_select = res_sel_q;
    assign res_last   = res_last_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_alu_sweep_driver.sv
// Directed bench for alu_sweep_driver: one instance with SETTLE=1 and one with
// SETTLE=3, each fed by a bench-side ALU model.
module tb_alu_sweep_driver;

    logic       clk;
    logic       rst;
    int         n_checks;
    int         n_fail;
    int         n_beats;

    // SETTLE=1 instance signals
    logic       in_valid, in_ready, res_valid, res_ready, res_last, busy, done;
    logic [7:0] in_a, in_b, alu_a, alu_b, alu_out, res_data;
    logic [2:0] alu_select, res_select;

    // SETTLE=3 instance signals
    logic       in_valid3, in_ready3, res_valid3, res_ready3, res_last3, busy3, done3;
    logic [7:0] in_a3, in_b3, alu_a3, alu_b3, alu_out3, res_data3, glitch3;
    logic [2:0] alu_select3, res_select3;

    // Bench ALU: distinct result for every select code.
    function automatic logic [7:0] alu_model(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        return (a + b) ^ {s, s, 2'b01};
    endfunction

    assign alu_out  = alu_model(alu_select, alu_a, alu_b);
    assign alu_out3 = alu_model(alu_select3, alu_a3, alu_b3) ^ glitch3;

    alu_sweep_driver #(.WIDTH(8), .SEL_W(3), .SETTLE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .alu_a(alu_a), .alu_b(alu_b),
        .alu_select(alu_select), .alu_out(alu_out), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_select(res_select),
        .res_last(res_last), .busy(busy), .done(done)
    );

    alu_sweep_driver #(.WIDTH(8), .SEL_W(3), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_a(in_a3), .in_b(in_b3), .alu_a(alu_a3), .alu_b(alu_b3),
        .alu_select(alu_select3), .alu_out(alu_out3), .res_valid(res_valid3),
        .res_ready(res_ready3), .res_data(res_data3), .res_select(res_select3),
        .res_last(res_last3), .busy(busy3), .done(done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
        n_checks++; if ({alu_a, alu_b, alu_select} !== 19'd0) begin n_fail++; $display("FAIL rst_alu: got %h expected 0", {alu_a, alu_b, alu_select}); end
        n_checks++; if ({res_valid, res_data, res_select, res_last, busy, done} !== 15'd0) begin n_fail++; $display("FAIL rst_res: got %h expected 0", {res_valid, res_data, res_select, res_last, busy, done}); end
        n_checks++; if ({res_valid3, busy3, done3, alu_select3} !== 6'd0) begin n_fail++; $display("FAIL rst_dut3: got %h expected 0", {res_valid3, busy3, done3, alu_select3}); end
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b expected 1", in_ready); end
        n_checks++; if (in_ready3 !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready3: got %b expected 1", in_ready3); end
    endtask

    // Runs one sweep on the SETTLE=1 instance and checks every cycle of it.
    task automatic do_sweep(input logic [7:0] a, input logic [7:0] b, input logic [7:0] na,
                            input logic [7:0] nb, input bit stall, input bit scramble, input bit hold);
        int  sel;
        bit  fin;
        logic [7:0] exp_d;
        in_a = a; in_b = b; in_valid = 1'b1; res_ready = 1'b1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL accept_ready: got %b expected 1", in_ready); end
        step();
        if (hold) begin in_a = na; in_b = nb; end else begin in_valid = 1'b0; end
        sel = 0;
        fin = 1'b0;
        for (int c = 0; c < 300 && !fin; c++) begin
            res_ready = stall ? ((c % 3) == 0) : 1'b1;
            if (scramble) begin in_a = 8'($urandom); in_b = 8'($urandom); end
            n_checks++; if (done !== (sel == 8)) begin n_fail++; $display("FAIL done: c=%0d got %b expected %b", c, done, sel == 8); end
            n_checks++; if (busy !== (sel != 8)) begin n_fail++; $display("FAIL busy: c=%0d got %b expected %b", c, busy, sel != 8); end
            n_checks++; if (in_ready !== (sel == 8)) begin n_fail++; $display("FAIL in_ready_sweep: c=%0d got %b expected %b", c, in_ready, sel == 8); end
            n_checks++; if ({alu_a, alu_b} !== {a, b}) begin n_fail++; $display("FAIL operand_hold: c=%0d got %h expected %h", c, {alu_a, alu_b}, {a, b}); end
            if (sel == 8) begin
                fin = 1'b1;
                if (!stall) begin
                    n_checks++; if (c !== 16) begin n_fail++; $display("FAIL sweep_len: got %0d expected 16", c); end
                end
            end else begin
                n_checks++; if (alu_select !== 3'(sel)) begin n_fail++; $display("FAIL alu_select: c=%0d got %0d expected %0d", c, alu_select, sel); end
                if (!stall) begin
                    n_checks++; if (res_valid !== ((c % 2) == 1)) begin n_fail++; $display("FAIL valid_timing: c=%0d got %b", c, res_valid); end
                end else if (c == 1) begin
                    n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %b expected 1", res_valid); end
                end
                if (res_valid) begin
                    exp_d = alu_model(3'(sel), a, b);
                    n_checks++; if (res_data !== exp_d) begin n_fail++; $display("FAIL res_data: sel=%0d got %h expected %h", sel, res_data, exp_d); end
                    n_checks++; if (res_select !== 3'(sel)) begin n_fail++; $display("FAIL res_select: got %0d expected %0d", res_select, sel); end
                    n_checks++; if (res_last !== (sel == 7)) begin n_fail++; $display("FAIL res_last: sel=%0d got %b", sel, res_last); end
                    if (res_ready) begin sel++; n_beats++; end
                end
                step();
            end
        end
        if (!fin) begin n_checks++; n_fail++; $display("FAIL sweep_timeout: got sel=%0d expected 8", sel); end
    endtask

    task automatic test_basic();
        do_sweep(8'h21, 8'h14, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        do_sweep(8'h21, 8'h14, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_settle3();
        int sel;
        bit fin;
        in_a3 = 8'h21; in_b3 = 8'h14; in_valid3 = 1'b1; res_ready3 = 1'b1;
        n_checks++; if (in_ready3 !== 1'b1) begin n_fail++; $display("FAIL s3_ready: got %b expected 1", in_ready3); end
        step();
        in_valid3 = 1'b0;
        sel = 0;
        fin = 1'b0;
        for (int c = 0; c < 100 && !fin; c++) begin
            // Corrupt alu_out only while a beat is waiting (after sampling).
            glitch3 = res_valid3 ? 8'h5A : 8'h00;
            n_checks++; if (done3 !== (sel == 8)) begin n_fail++; $display("FAIL s3_done: c=%0d got %b", c, done3); end
            if (sel == 8) begin
                fin = 1'b1;
                n_checks++; if (c !== 32) begin n_fail++; $display("FAIL s3_len: got %0d expected 32", c); end
            end else begin
                n_checks++; if (res_valid3 !== (c >= 3 && ((c - 3) % 4) == 0)) begin n_fail++; $display("FAIL s3_valid_timing: c=%0d got %b", c, res_valid3); end
                n_checks++; if (alu_select3 !== 3'(sel)) begin n_fail++; $display("FAIL s3_select: c=%0d got %0d expected %0d", c, alu_select3, sel); end
                if (res_valid3) begin
                    n_checks++; if (res_data3 !== alu_model(3'(sel), 8'h21, 8'h14)) begin n_fail++; $display("FAIL s3_data: sel=%0d got %h expected %h", sel, res_data3, alu_model(3'(sel), 8'h21, 8'h14)); end
                    n_checks++; if (res_select3 !== 3'(sel)) begin n_fail++; $display("FAIL s3_res_select: got %0d expected %0d", res_select3, sel); end
                    sel++;
                end
                step();
            end
        end
        glitch3 = 8'h00;
        if (!fin) begin n_checks++; n_fail++; $display("FAIL s3_timeout: got sel=%0d expected 8", sel); end
    endtask

    task automatic test_reset_mid();
        bit found;
        in_a = 8'h5C; in_b = 8'h33; in_valid = 1'b1; res_ready = 1'b1;
        step();
        in_valid = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (res_valid && res_select == 3'd4) begin
                found = 1'b1;
                res_ready = 1'b0;
            end else begin
                step();
            end
        end
        n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL rmid_reach_sel4: got %b expected 1", found); end
        rst = 1'b1;
        step();
        n_checks++; if ({alu_a, alu_b, alu_select} !== 19'd0) begin n_fail++; $display("FAIL rmid_alu: got %h expected 0", {alu_a, alu_b, alu_select}); end
        n_checks++; if ({res_valid, res_data, res_select, res_last, busy, done} !== 15'd0) begin n_fail++; $display("FAIL rmid_res: got %h expected 0", {res_valid, res_data, res_select, res_last, busy, done}); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_ready_in_rst: got %b expected 0", in_ready); end
        rst = 1'b0;
        res_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready_release: got %b expected 1", in_ready); end
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++; if ({done, res_valid, busy} !== 3'b000) begin n_fail++; $display("FAIL rmid_quiet: i=%0d got %b expected 000", i, {done, res_valid, busy}); end
        end
    endtask

    task automatic test_back_to_back();
        n_beats = 0;
        do_sweep(8'h21, 8'h14, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
        do_sweep(8'hFF, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        n_checks++; if (n_beats !== 16) begin n_fail++; $display("FAIL b2b_beats: got %0d expected 16", n_beats); end
    endtask

    task automatic test_operand_scramble();
        do_sweep(8'h21, 8'h14, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        in_a = 8'h00; in_b = 8'h00;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; n_beats = 0;
        rst = 1'b1;
        in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; res_ready = 1'b1;
        in_valid3 = 1'b0; in_a3 = 8'h00; in_b3 = 8'h00; res_ready3 = 1'b1; glitch3 = 8'h00;
        test_reset();
        test_basic();
        step();
        test_stall();
        step();
        test_settle3();
        step();
        test_reset_mid();
        test_back_to_back();
        step();
        test_operand_scramble();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
